// File: rtl/ov7670_pkg.sv
// Shared types, bar colour table and byte-split helper for the OV7670 stream generator.
package ov7670_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} stream_state_t;

    typedef enum logic [1:0] {BARS, GRAD, CHECK, SOLID} pattern_t;

    // White, yellow, cyan, green, magenta, red, blue, black in RGB565.
    localparam logic [15:0] BAR_RGB [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    // Byte 0 carries {R[4:0],G[5:3]}, byte 1 carries {G[2:0],B[4:0]}.
    function automatic logic [7:0] rgb565_byte(input logic [15:0] pix, input logic b);
        return b ? pix[7:0] : pix[15:8];
    endfunction

endpackage

// File: rtl/ov7670_stream_gen_if.sv
// Camera-side parallel video port plus the frame controls that steer the generator.
interface ov7670_stream_gen_if;
    logic        en;
    logic [1:0]  mode;
    logic [15:0] solid_rgb;
    logic        pixel_clk;
    logic        href;
    logic        vsync;
    logic [7:0]  data;
    logic        busy;
    logic        frame_done;

    modport master (input en, mode, solid_rgb,
                    output pixel_clk, href, vsync, data, busy, frame_done);
    modport slave  (output en, mode, solid_rgb,
                    input pixel_clk, href, vsync, data, busy, frame_done);
endinterface

// File: rtl/ov7670_pattern_pixel.sv
// Test-pattern colour for pixel (x,y) in RGB565.
// Latency: combinational.
// Backpressure: none.
module ov7670_pattern_pixel
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE = 320,
    parameter int XW       = 9,
    parameter int YW       = 8
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  pattern_t      mode,
    input  logic [15:0]   solid_rgb,
    output logic [15:0]   pix
);
    localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

    logic [15:0] bar_full;
    logic [2:0]  bar;

    assign bar_full = 16'(x) / 16'(BAR_W);
    // Widths that are not a multiple of 8 leave a remainder; it stays in the last bar.
    assign bar      = (bar_full > 16'd7) ? 3'd7 : 3'(bar_full);

    always_comb begin
        pix = 16'h0000;
        case (mode)
            BARS:    pix = BAR_RGB[bar];
            GRAD:    pix = {5'(16'(x) >> 3), 6'(16'(y) >> 2), ~5'(16'(x) >> 3)};
            CHECK:   pix = (|((16'(x) ^ 16'(y)) & 16'h0008)) ? 16'hFFFF : 16'h0000;
            SOLID:   pix = solid_rgb;
            default: pix = 16'h0000;
        endcase
    end
endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 transmit model: pclk = clk/2, href/vsync/data RGB565 frames from test patterns.
// Latency: outputs registered, updated only on the clk edge where pixel_clk falls.
// Backpressure: none; frames free-run once started, en is sampled only between frames.
module ov7670_stream_gen
    import ov7670_pkg::*;
#(
    parameter int H_ACTIVE    = 320,
    parameter int V_ACTIVE    = 240,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic               clk,
    input  logic               reset,
    ov7670_stream_gen_if.master vid
);
    localparam int LINE    = 2 * H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
    localparam int HW      = $clog2(LINE + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);
    localparam int XW      = $clog2(H_ACTIVE + 1);
    localparam int YW      = $clog2(V_ACTIVE + 1);

    stream_state_t state, state_n;
    logic [HW-1:0] hcnt, hcnt_n;
    logic [VW-1:0] vcnt, vcnt_n, last_line;
    logic          pclk_q, tick, frame_end;
    pattern_t      mode_q;
    logic [15:0]   solid_q, pix;
    logic          href_n, vsync_n, busy_n;
    logic [7:0]    data_n;
    logic          href_q, vsync_q, busy_q, frame_done_q;
    logic [7:0]    data_q;

    // pclk falls on this edge; every video output moves only here.
    assign tick = pclk_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pclk_q  <= 1'b0;
            state   <= IDLE;
            hcnt    <= '0;
            vcnt    <= '0;
            mode_q  <= BARS;
            solid_q <= 16'h0000;
        end else begin
            pclk_q <= ~pclk_q;
            state  <= state_n;
            hcnt   <= hcnt_n;
            vcnt   <= vcnt_n;
            if (tick && state == IDLE && vid.en) begin
                mode_q  <= pattern_t'(vid.mode);
                solid_q <= vid.solid_rgb;
            end
        end
    end

    always_comb begin
        case (state)
            VSYNC:   last_line = VW'(VSYNC_LINES - 1);
            VBACK:   last_line = VW'(V_BACK - 1);
            ACTIVE:  last_line = VW'(V_ACTIVE - 1);
            default: last_line = VW'(V_FRONT - 1);
        endcase
    end

    always_comb begin
        state_n   = state;
        hcnt_n    = hcnt;
        vcnt_n    = vcnt;
        frame_end = 1'b0;
        if (tick) begin
            if (state == IDLE) begin
                if (vid.en) begin
                    state_n = VSYNC;
                    hcnt_n  = '0;
                    vcnt_n  = '0;
                end
            end else if (hcnt == HW'(LINE - 1)) begin
                hcnt_n = '0;
                if (vcnt == last_line) begin
                    vcnt_n = '0;
                    case (state)
                        VSYNC:   state_n = VBACK;
                        VBACK:   state_n = ACTIVE;
                        ACTIVE:  state_n = VFRONT;
                        default: state_n = IDLE;
                    endcase
                    frame_end = (state == VFRONT);
                end else begin
                    vcnt_n = vcnt + 1'b1;
                end
            end else begin
                hcnt_n = hcnt + 1'b1;
            end
        end
    end

    ov7670_pattern_pixel #(
        .H_ACTIVE (H_ACTIVE),
        .XW       (XW),
        .YW       (YW)
    ) u_pattern (
        .x         (XW'(hcnt_n >> 1)),
        .y         (YW'(vcnt_n)),
        .mode      (mode_q),
        .solid_rgb (solid_q),
        .pix       (pix)
    );

    // Decoded from the post-tick position so registered outputs line up with the counters.
    always_comb begin
        busy_n  = (state_n != IDLE);
        vsync_n = (state_n == VSYNC);
        href_n  = (state_n == ACTIVE) && (hcnt_n < HW'(2 * H_ACTIVE));
        data_n  = href_n ? rgb565_byte(pix, hcnt_n[0]) : 8'h00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            busy_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= frame_end;
            if (tick) begin
                href_q  <= href_n;
                vsync_q <= vsync_n;
                busy_q  <= busy_n;
                data_q  <= data_n;
            end
        end
    end

    assign vid.pixel_clk  = pclk_q;
    assign vid.href       = href_q;
    assign vid.vsync      = vsync_q;
    assign vid.data       = data_q;
    assign vid.busy       = busy_q;
    assign vid.frame_done = frame_done_q;
endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Directed bench for ov7670_stream_gen: small-geometry frames checked byte by byte.
`timescale 1ns/1ps
module tb_ov7670_stream_gen;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ov7670_stream_gen_if vif ();
    ov7670_stream_gen_if vif2 ();

    ov7670_stream_gen #(
        .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut (
        .clk(clk), .reset(reset), .vid(vif)
    );

    ov7670_stream_gen #(
        .H_ACTIVE(32), .V_ACTIVE(32), .H_BLANK(4), .VSYNC_LINES(1), .V_BACK(1), .V_FRONT(1)
    ) dut_chk (
        .clk(clk), .reset(reset), .vid(vif2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int vs_ticks, hr_bursts, fd_cnt, unstable;
    logic href_prev;
    logic [10:0] snap;
    logic [7:0] bytes  [$];
    logic [7:0] bytes2 [$];
    logic [15:0] bar_tab [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Video monitor for the small DUT, sampling mid-way through pclk high.
    always @(negedge clk) begin
        if (vif.frame_done) fd_cnt++;
        if (vif.pixel_clk) begin
            if ({vif.href, vif.vsync, vif.busy, vif.data} !== snap) unstable++;
            if (vif.vsync) vs_ticks++;
            if (vif.href) begin
                bytes.push_back(vif.data);
                if (!href_prev) hr_bursts++;
            end
            href_prev = vif.href;
        end else begin
            snap = {vif.href, vif.vsync, vif.busy, vif.data};
        end
    end

    always @(negedge clk) begin
        if (vif2.pixel_clk && vif2.href) bytes2.push_back(vif2.data);
    end

    task automatic clear_stats();
        vs_ticks = 0; hr_bursts = 0; fd_cnt = 0; unstable = 0;
        href_prev = 1'b0;
        bytes.delete();
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return vif.busy;
            1:       return vif.frame_done;
            2:       return vif.href;
            3:       return vif2.frame_done;
            4:       return vif2.busy;
            default: return (hr_bursts >= 2);
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag);
        logic hit = 1'b0;
        for (int k = 0; k < budget && !hit; k++) begin
            @(negedge clk);
            hit = sig(sel);
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    function automatic int alt_err();
        int e = 0;
        for (int i = 0; i < bytes.size(); i++)
            if (bytes[i] !== ((i % 2 == 1) ? 8'h1F : 8'hF8)) e++;
        return e;
    endfunction

    function automatic int bar_err();
        int e = 0;
        int x;
        for (int i = 0; i < bytes.size(); i++) begin
            x = (i % 16) / 2;
            if (bytes[i] !== ((i % 2 == 1) ? bar_tab[x][7:0] : bar_tab[x][15:8])) e++;
        end
        return e;
    endfunction

    function automatic logic [7:0] b2_at(input int i);
        return (i < bytes2.size()) ? bytes2[i] : 8'hxx;
    endfunction

    task automatic run_one(input logic [1:0] m, input logic [15:0] rgb);
        clear_stats();
        vif.mode = m; vif.solid_rgb = rgb; vif.en = 1'b1;
        wait_for(0, 10, "frame_start");
        vif.en = 1'b0;
        wait_for(1, 600, "frame_done_seen");
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int toggles, nz, k;
        logic prev;
        bar_tab = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        vif.en = 1'b0;  vif.mode = 2'd0;  vif.solid_rgb = 16'h0000;
        vif2.en = 1'b0; vif2.mode = 2'd0; vif2.solid_rgb = 16'h0000;
        clear_stats();

        // Reset values and idle behaviour
        repeat (3) @(negedge clk);
        check_eq("rst_pclk", 32'(vif.pixel_clk), 32'd0);
        check_eq("rst_href", 32'(vif.href), 32'd0);
        check_eq("rst_vsync", 32'(vif.vsync), 32'd0);
        check_eq("rst_busy", 32'(vif.busy), 32'd0);
        check_eq("rst_data", 32'(vif.data), 32'h00);
        check_eq("rst_fdone", 32'(vif.frame_done), 32'd0);
        reset = 1'b1;
        toggles = 0; prev = vif.pixel_clk;
        repeat (100) begin
            @(negedge clk);
            if (vif.pixel_clk !== prev) toggles++;
            prev = vif.pixel_clk;
        end
        check_eq("idle_pclk_toggles", 32'(toggles), 32'd100);
        check_eq("idle_href", 32'(vif.href), 32'd0);
        check_eq("idle_vsync", 32'(vif.vsync), 32'd0);
        check_eq("idle_busy", 32'(vif.busy), 32'd0);
        check_eq("idle_data", 32'(vif.data), 32'h00);
        check_eq("idle_no_frame", 32'(fd_cnt), 32'd0);

        // Solid magenta frame
        run_one(2'd3, 16'hF81F);
        check_eq("solid_vsync_ticks", 32'(vs_ticks), 32'd20);
        check_eq("solid_href_bursts", 32'(hr_bursts), 32'd4);
        check_eq("solid_byte_count", 32'(bytes.size()), 32'd64);
        check_eq("solid_byte_errors", 32'(alt_err()), 32'd0);
        check_eq("solid_first_byte", 32'(bytes[0]), 32'hF8);
        check_eq("solid_second_byte", 32'(bytes[1]), 32'h1F);
        check_eq("solid_frame_done", 32'(fd_cnt), 32'd1);
        check_eq("solid_stable_at_rise", 32'(unstable), 32'd0);
        check_eq("solid_busy_after", 32'(vif.busy), 32'd0);

        // Colour bars
        run_one(2'd0, 16'h0000);
        check_eq("bars_byte_count", 32'(bytes.size()), 32'd64);
        check_eq("bars_byte_errors", 32'(bar_err()), 32'd0);
        check_eq("bars_yellow_hi", 32'(bytes[2]), 32'hFF);
        check_eq("bars_yellow_lo", 32'(bytes[3]), 32'hE0);
        check_eq("bars_magenta_hi", 32'(bytes[8]), 32'hF8);
        check_eq("bars_line3_black", 32'(bytes[63]), 32'h00);

        // Checkerboard on the 32x32 instance
        bytes2.delete();
        vif2.mode = 2'd2; vif2.en = 1'b1;
        wait_for(4, 10, "chk_start");
        vif2.en = 1'b0;
        wait_for(3, 6000, "chk_done");
        nz = 0;
        for (int i = 0; i < 16; i++) if (b2_at(i) !== 8'h00) nz++;
        check_eq("chk_byte_count", 32'(bytes2.size()), 32'd2048);
        check_eq("chk_x0_7_y0_black", 32'(nz), 32'd0);
        check_eq("chk_x8_y0_hi", 32'(b2_at(16)), 32'hFF);
        check_eq("chk_x8_y0_lo", 32'(b2_at(17)), 32'hFF);
        check_eq("chk_x0_y8_hi", 32'(b2_at(512)), 32'hFF);
        check_eq("chk_x8_y8_hi", 32'(b2_at(528)), 32'h00);
        check_eq("chk_x8_y8_lo", 32'(b2_at(529)), 32'h00);

        // en dropped and mode changed during the second active line
        clear_stats();
        vif.mode = 2'd3; vif.solid_rgb = 16'hF81F; vif.en = 1'b1;
        wait_for(0, 10, "drop_start");
        wait_for(5, 400, "drop_line2");
        vif.en = 1'b0; vif.mode = 2'd0;
        wait_for(1, 600, "drop_done");
        repeat (300) @(negedge clk);
        check_eq("drop_frame_done_once", 32'(fd_cnt), 32'd1);
        check_eq("drop_idle_busy", 32'(vif.busy), 32'd0);
        check_eq("drop_vsync_ticks", 32'(vs_ticks), 32'd20);
        check_eq("drop_byte_count", 32'(bytes.size()), 32'd64);
        check_eq("drop_mode_held", 32'(alt_err()), 32'd0);

        // Back-to-back frames with en held high
        clear_stats();
        vif.mode = 2'd3; vif.en = 1'b1;
        wait_for(1, 700, "b2b_done1");
        check_eq("b2b_busy_at_done", 32'(vif.busy), 32'd0);
        k = 0;
        while (!vif.vsync && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq("b2b_vsync_delay_clks", 32'(k), 32'd2);
        vif.en = 1'b0;
        wait_for(1, 700, "b2b_done2");
        repeat (4) @(negedge clk);
        check_eq("b2b_frame_count", 32'(fd_cnt), 32'd2);
        check_eq("b2b_byte_count", 32'(bytes.size()), 32'd128);

        // Asynchronous reset in the middle of an active line
        clear_stats();
        vif.en = 1'b1;
        wait_for(2, 400, "mid_href_on");
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_href", 32'(vif.href), 32'd0);
        check_eq("mid_rst_vsync", 32'(vif.vsync), 32'd0);
        check_eq("mid_rst_data", 32'(vif.data), 32'h00);
        check_eq("mid_rst_busy", 32'(vif.busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        wait_for(0, 10, "rst_restart");
        vif.en = 1'b0;
        wait_for(1, 700, "rst_frame_done");
        repeat (4) @(negedge clk);
        check_eq("rst_vsync_ticks", 32'(vs_ticks), 32'd20);
        check_eq("rst_href_bursts", 32'(hr_bursts), 32'd4);
        check_eq("rst_byte_count", 32'(bytes.size()), 32'd64);
        check_eq("rst_frame_done_once", 32'(fd_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
